// File: rtl/sha256_block_sequencer.sv
// Multi-block SHA-256 sequencer: fetches 16-word blocks from memory, drives a shared
// compression core with the running chaining value, and writes the final digest back.
module sha256_block_sequencer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned NBLK_W  = 8,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_addr,
  input  logic [NBLK_W-1:0] num_blocks,
  input  logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              core_start,
  output logic [255:0]      core_h,
  output logic [511:0]      core_w,
  input  logic              core_done,
  input  logic [255:0]      core_hout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {StIdle, StFetch, StRun, StWait, StWrite, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [NBLK_W-1:0] blocks_left_q;
  logic [4:0]        fetch_cnt_q;
  logic [3:0]        wr_idx_q;
  logic [TW-1:0]     tmo_cnt_q;

  function automatic logic [31:0] word_of(input logic [255:0] v, input logic [2:0] j);
    word_of = v[int'(3'd7 - j) * 32 +: 32];
  endfunction

  // core_h doubles as the chaining register; core_w is the block shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      core_start    <= 1'b0;
      core_h        <= IV;
      core_w        <= '0;
      rd_ptr_q      <= '0;
      out_addr_q    <= '0;
      blocks_left_q <= '0;
      fetch_cnt_q   <= '0;
      wr_idx_q      <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy          <= 1'b1;
            error         <= 1'b0;
            core_h        <= IV;
            out_addr_q    <= out_addr;
            blocks_left_q <= num_blocks;
            if (num_blocks == '0) begin
              state_q   <= StWrite;
              mem_we    <= 1'b1;
              mem_addr  <= out_addr;
              mem_wdata <= IV[255:224];
              wr_idx_q  <= 4'd1;
            end else begin
              state_q     <= StFetch;
              mem_addr    <= msg_addr;
              rd_ptr_q    <= msg_addr + ADDR_W'(1);
              fetch_cnt_q <= '0;
            end
          end
        end

        // Issue on counts 0..14 (first issue happened on entry), capture on counts 1..16.
        StFetch: begin
          if (fetch_cnt_q != 5'd0) begin
            core_w <= {core_w[479:0], mem_rdata};
          end
          if (fetch_cnt_q < 5'd15) begin
            mem_addr <= rd_ptr_q;
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          end
          if (fetch_cnt_q == 5'd16) begin
            state_q    <= StRun;
            core_start <= 1'b1;
          end else begin
            fetch_cnt_q <= fetch_cnt_q + 5'd1;
          end
        end

        StRun: begin
          core_start <= 1'b0;
          tmo_cnt_q  <= TW'(1);
          state_q    <= StWait;
        end

        // tmo_cnt_q equals the number of cycles elapsed since the core_start cycle.
        StWait: begin
          if (core_done) begin
            core_h        <= core_hout;
            blocks_left_q <= blocks_left_q - NBLK_W'(1);
            if (blocks_left_q == NBLK_W'(1)) begin
              state_q   <= StWrite;
              mem_we    <= 1'b1;
              mem_addr  <= out_addr_q;
              mem_wdata <= core_hout[255:224];
              wr_idx_q  <= 4'd1;
            end else begin
              state_q     <= StFetch;
              mem_addr    <= rd_ptr_q;
              rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
              fetch_cnt_q <= '0;
            end
          end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
            error   <= 1'b1;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end

        StWrite: begin
          if (wr_idx_q == 4'd8) begin
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            mem_addr  <= out_addr_q + ADDR_W'(wr_idx_q);
            mem_wdata <= word_of(core_h, wr_idx_q[2:0]);
            wr_idx_q  <= wr_idx_q + 4'd1;
          end
        end

        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  a_core_start_pulse: assert property (@(posedge clk) disable iff (rst) core_start |=> !core_start);
  a_done_pulse:       assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_we_when_busy:     assert property (@(posedge clk) disable iff (rst) mem_we |-> busy);

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer: memory and compression-core models,
// table of hash jobs, plus timeout, start-while-busy and reset-mid-write sequences.
module tb_sha256_block_sequencer;

  localparam int ADDR_W  = 16;
  localparam int NBLK_W  = 8;
  localparam int TIMEOUT = 128;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_D = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] TWO_D = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [511:0] ABC_W = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO_W1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_W2 = {{15{32'h0}}, 32'h000001c0};

  localparam logic [31:0] KTAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] msg_addr = '0;
  logic [NBLK_W-1:0] num_blocks = '0;
  logic [ADDR_W-1:0] out_addr = '0;
  logic              busy, done, error, mem_we, core_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [255:0]      core_h;
  logic [511:0]      core_w;
  logic              core_done = 1'b0;
  logic [255:0]      core_hout = '0;

  always #5 clk = ~clk;

  sha256_block_sequencer #(.ADDR_W(ADDR_W), .NBLK_W(NBLK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_addr(msg_addr), .num_blocks(num_blocks),
    .out_addr(out_addr), .busy(busy), .done(done), .error(error), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_start(core_start),
    .core_h(core_h), .core_w(core_w), .core_done(core_done), .core_hout(core_hout)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
           + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KTAB[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Synchronous-read memory: address seen in cycle k, data visible in cycle k+1.
  logic [31:0] mem [0:65535];
  int wr_cnt = 0;
  initial begin
    logic [31:0] rd_latch;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_cnt++;
      end
      rd_latch = mem[mem_addr];
      @(posedge clk);
      #1 mem_rdata = rd_latch;
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Core model: core_done visible core_lat cycles after the core_start cycle; 0 = never.
  int core_lat = 1;
  int n_starts = 0;
  logic [255:0] hist_h [0:3];
  logic [255:0] hist_out [0:3];
  logic [511:0] hist_w [0:3];
  initial begin
    logic [255:0] res;
    forever begin
      @(negedge clk);
      if (core_start) begin
        res = sha_compress(core_h, core_w);
        if (n_starts < 4) begin
          hist_h[n_starts] = core_h;
          hist_w[n_starts] = core_w;
          hist_out[n_starts] = res;
        end
        n_starts++;
        if (core_lat > 0) begin
          repeat (core_lat) @(posedge clk);
          #1 core_done = 1'b1;
          core_hout = res;
          @(posedge clk);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  task automatic load_block(input logic [15:0] a, input logic [511:0] b);
    for (int j = 0; j < 16; j++) mem[a + 16'(j)] = b[511 - 32 * j -: 32];
  endtask

  function automatic logic [255:0] read_digest(input logic [15:0] a);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[255 - 32 * j -: 32] = mem[a + 16'(j)];
    return r;
  endfunction

  // lat = index of the cycle where done is visible, counting the start-sampling edge as 0.
  task automatic run_job(input logic [15:0] a, input logic [7:0] nb, input logic [15:0] oa,
                         input bit poke, output int lat, output logic err_early,
                         output logic err_done, output logic busy_done);
    @(negedge clk);
    msg_addr = a; num_blocks = nb; out_addr = oa; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    err_early = error;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
      start = poke && (lat == 5 || lat == 20);
    end
    if (lat >= 3000) chk("done_timeout", 0, 1);
    err_done = error;
    busy_done = busy;
    start = poke;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  typedef struct {
    string        name;
    logic [15:0]  msg_addr;
    logic [7:0]   nblk;
    logic [15:0]  out_addr;
    int           tcore;
    bit           poke;
    logic [255:0] digest;
    logic [511:0] w0;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [15:0] ma, input logic [7:0] nb,
                              input logic [15:0] oa, input int tc, input bit pk,
                              input logic [255:0] dg, input logic [511:0] w0);
    vec_t v;
    v.name = nm; v.msg_addr = ma; v.nblk = nb; v.out_addr = oa;
    v.tcore = tc; v.poke = pk; v.digest = dg; v.w0 = w0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [0:4];
    int lat, wr0, d0, exp_lat, nwe;
    logic err_early, err_done, busy_done;

    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    load_block(16'h0100, ABC_W);
    load_block(16'h0200, TWO_W1);
    load_block(16'h0210, TWO_W2);
    load_block(16'hfff8, ABC_W);

    vecs[0] = mk("abc",       16'h0100, 8'd1, 16'h1000, 5,       1'b0, ABC_D, ABC_W);
    vecs[1] = mk("two_block", 16'h0200, 8'd2, 16'h1010, 3,       1'b0, TWO_D, TWO_W1);
    vecs[2] = mk("zero_blk",  16'h0100, 8'd0, 16'h1020, 2,       1'b0, IV,    '0);
    vecs[3] = mk("wrap_poke", 16'hfff8, 8'd1, 16'h1030, 1,       1'b1, ABC_D, ABC_W);
    vecs[4] = mk("tcore_max", 16'h0100, 8'd1, 16'h1040, TIMEOUT, 1'b0, ABC_D, ABC_W);

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_h", core_h, IV);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      core_lat = vecs[i].tcore;
      n_starts = 0;
      wr0 = wr_cnt;
      d0 = done_cnt;
      run_job(vecs[i].msg_addr, vecs[i].nblk, vecs[i].out_addr, vecs[i].poke,
              lat, err_early, err_done, busy_done);
      exp_lat = int'(vecs[i].nblk) * (18 + vecs[i].tcore) + 9;
      chk({vecs[i].name, "_latency"}, lat, exp_lat);
      chk({vecs[i].name, "_error"}, err_done, 0);
      chk({vecs[i].name, "_busy_at_done"}, busy_done, 1);
      chk({vecs[i].name, "_busy_after"}, busy, 0);
      chk({vecs[i].name, "_done_count"}, done_cnt - d0, 1);
      chk({vecs[i].name, "_core_starts"}, n_starts, vecs[i].nblk);
      chk({vecs[i].name, "_writes"}, wr_cnt - wr0, 8);
      chk({vecs[i].name, "_digest"}, read_digest(vecs[i].out_addr), vecs[i].digest);
      if (vecs[i].nblk != 0) begin
        chk({vecs[i].name, "_h_blk0"}, hist_h[0], IV);
        chk({vecs[i].name, "_w_blk0"}, hist_w[0], vecs[i].w0);
      end
      if (vecs[i].nblk == 2) begin
        chk({vecs[i].name, "_h_chain"}, hist_h[1], hist_out[0]);
        chk({vecs[i].name, "_w_blk1"}, hist_w[1], TWO_W2);
      end
    end

    // Core never answers: error and done arrive one cycle after the counter hits TIMEOUT.
    core_lat = 0;
    n_starts = 0;
    wr0 = wr_cnt;
    run_job(16'h0100, 8'd1, 16'h1050, 1'b0, lat, err_early, err_done, busy_done);
    chk("tmo_latency", lat, 18 + TIMEOUT + 1);
    chk("tmo_error", err_done, 1);
    chk("tmo_writes", wr_cnt - wr0, 0);
    chk("tmo_core_starts", n_starts, 1);
    chk("tmo_error_sticky", error, 1);

    core_lat = 4;
    run_job(16'h0100, 8'd1, 16'h1060, 1'b0, lat, err_early, err_done, busy_done);
    chk("after_tmo_error_cleared", err_early, 0);
    chk("after_tmo_error", err_done, 0);
    chk("after_tmo_digest", read_digest(16'h1060), ABC_D);

    // Reset during the third write cycle.
    core_lat = 2;
    @(negedge clk);
    msg_addr = 16'h0100; num_blocks = 8'd1; out_addr = 16'h1070; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nwe = 0;
    for (int c = 0; c < 500 && nwe < 3; c++) begin
      @(negedge clk);
      if (mem_we) nwe++;
    end
    chk("rst_mid_reached_write3", nwe, 3);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    chk("rst_mid_core_w", core_w, 0);
    @(negedge clk);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_we_next", mem_we, 0);
    rst = 1'b0;

    run_job(16'h0100, 8'd1, 16'h1080, 1'b0, lat, err_early, err_done, busy_done);
    chk("post_rst_latency", lat, 1 * (18 + 2) + 9);
    chk("post_rst_digest", read_digest(16'h1080), ABC_D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
